adc_scan_ctrl: RTL and testbench

Sequencer for the on-chip 12-bit ADC hard macro. Scans up to eight analog inputs round-robin under a channel mask, issues start-of-conversion, waits for end-of-conversion with a timeout, and publishes each result with its channel tag. Also keeps a registered 2-bit battery level for one designated channel. Sits between the PLL-derived ADC clock domain and the `adc` macro instance, replacing free-running `soc` tie-offs.

---
 rtl/adc_scan_ctrl.sv | 251 +++++++++++++++++++++++++
 tb/tb_adc_scan_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_scan_ctrl.sv
// -----------------------------------------------------------------------------
// adc_scan_ctrl
//
// Round-robin scan sequencer for the on-chip 12-bit ADC hard macro. Walks the
// channels enabled in chan_mask, lets the analog mux settle, fires a one-cycle
// start-of-conversion, waits for a rising end-of-conversion (with timeout) and
// publishes each result tagged with its channel. A 2-bit battery level is kept
// for channel BATT_CH.
//
// Optional feature macro: ADC_SCAN_AVG_EN
//   When defined, each channel visit runs 4 back-to-back conversions (no
//   re-settle) and publishes their truncated mean. A timeout on any of the 4
//   discards the visit.
//
// Ports
//   clk_adc       in   ADC clock (same net as the macro); sole clock
//   rst_n         in   asynchronous active-low reset
//   enable        in   scan enable (level)
//   chan_mask     in   [7:0] bit i set = channel i scanned
//   adc_eoc       in   macro end-of-conversion
//   adc_dout      in   [11:0] macro conversion data
//   adc_soc       out  start-of-conversion pulse
//   adc_s         out  [2:0] channel select
//   result_valid  out  one-cycle result strobe
//   result_data   out  [11:0] result, held until next strobe
//   result_chan   out  [2:0] channel of result_data
//   batt_level    out  [1:0] 0 = no sample, 1 full, 2 mid, 3 low
//   err_timeout   out  sticky timeout flag
// -----------------------------------------------------------------------------
module adc_scan_ctrl #(
    parameter int SETTLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 1023,
    parameter int BATT_CH     = 1,
    parameter int BATT_HI     = 2699,
    parameter int BATT_LO     = 2389
) (
    input  logic        clk_adc,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [7:0]  chan_mask,
    input  logic        adc_eoc,
    input  logic [11:0] adc_dout,
    output logic        adc_soc,
    output logic [2:0]  adc_s,
    output logic        result_valid,
    output logic [11:0] result_data,
    output logic [2:0]  result_chan,
    output logic [1:0]  batt_level,
    output logic        err_timeout
);

    typedef enum logic [2:0] {
        IDLE, SELECT, SETTLE, START, WAIT, CAPTURE, NEXT
    } state_t;

    localparam logic [15:0] SETTLE_LOAD  = 16'(SETTLE_CYC);
    // WAIT fires on the cycle the counter is at 1, so the sticky flag becomes
    // visible exactly TIMEOUT_CYC cycles after the soc cycle.
    localparam logic [15:0] TIMEOUT_LOAD = 16'(TIMEOUT_CYC - 1);
    localparam logic [2:0]  BATT_CH_V    = 3'(BATT_CH);
    localparam logic [11:0] BATT_HI_V    = 12'(BATT_HI);
    localparam logic [11:0] BATT_LO_V    = 12'(BATT_LO);

    state_t      state_reg, state_next;
    logic [15:0] cnt_reg, cnt_next;
    logic [2:0]  chan_reg, chan_next;
    logic        eoc_prev_reg;
    logic        soc_reg, soc_next;
    logic        result_valid_reg, result_valid_next;
    logic [11:0] result_data_reg, result_data_next;
    logic [2:0]  result_chan_reg, result_chan_next;
    logic [1:0]  batt_level_reg, batt_level_next;
    logic        err_timeout_reg, err_timeout_next;
    logic [11:0] capture_value;

`ifdef ADC_SCAN_AVG_EN
    logic [13:0] acc_reg, acc_next;
    logic [1:0]  conv_reg, conv_next;
    assign capture_value = acc_reg[13:2];
`else
    logic [11:0] sample_reg, sample_next;
    assign capture_value = sample_reg;
`endif

    logic eoc_rise;
    assign eoc_rise = adc_eoc & ~eoc_prev_reg;

    // Next-channel search: rotate the mask so that bit 0 is the first
    // candidate, then take the lowest set bit. From IDLE the search starts at
    // channel 0 (lowest set bit); from NEXT it starts just above the current
    // channel, so a lone set bit wraps back onto itself.
    logic [2:0] search_base;
    logic [7:0] rot_mask;
    logic [2:0] pick_off;
    logic [2:0] pick_chan;

    assign search_base = (state_reg == IDLE) ? 3'd0 : chan_reg + 3'd1;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_rot
            assign rot_mask[gi] = chan_mask[search_base + 3'(gi)];
        end
    endgenerate

    always_comb begin
        pick_off = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (rot_mask[i]) pick_off = 3'(i);
        end
    end

    assign pick_chan = search_base + pick_off;

    // Next-state and datapath
    always_comb begin
        state_next        = state_reg;
        cnt_next          = cnt_reg;
        chan_next         = chan_reg;
        result_valid_next = 1'b0;
        result_data_next  = result_data_reg;
        result_chan_next  = result_chan_reg;
        batt_level_next   = batt_level_reg;
        err_timeout_next  = err_timeout_reg;
`ifdef ADC_SCAN_AVG_EN
        acc_next          = acc_reg;
        conv_next         = conv_reg;
`else
        sample_next       = sample_reg;
`endif

        case (state_reg)
            IDLE: begin
                if (enable && (|chan_mask)) begin
                    chan_next  = pick_chan;
                    state_next = SELECT;
                end
            end
            SELECT: begin
                cnt_next   = SETTLE_LOAD;
`ifdef ADC_SCAN_AVG_EN
                acc_next   = 14'd0;
                conv_next  = 2'd0;
`endif
                state_next = SETTLE;
            end
            SETTLE: begin
                if (cnt_reg == 16'd0) begin
                    state_next = START;
                end else begin
                    cnt_next = cnt_reg - 16'd1;
                end
            end
            START: begin
                cnt_next   = TIMEOUT_LOAD;
                state_next = WAIT;
            end
            WAIT: begin
                if (eoc_rise) begin
`ifdef ADC_SCAN_AVG_EN
                    acc_next   = acc_reg + {2'b00, adc_dout};
                    conv_next  = conv_reg + 2'd1;
                    state_next = (conv_reg == 2'd3) ? CAPTURE : START;
`else
                    sample_next = adc_dout;
                    state_next  = CAPTURE;
`endif
                end else if (cnt_reg <= 16'd1) begin
                    err_timeout_next = 1'b1;
                    state_next       = NEXT;
                end else begin
                    cnt_next = cnt_reg - 16'd1;
                end
            end
            CAPTURE: begin
                result_valid_next = 1'b1;
                result_data_next  = capture_value;
                result_chan_next  = chan_reg;
                if (chan_reg == BATT_CH_V) begin
                    if (capture_value > BATT_HI_V) begin
                        batt_level_next = 2'd1;
                    end else if (capture_value > BATT_LO_V) begin
                        batt_level_next = 2'd2;
                    end else begin
                        batt_level_next = 2'd3;
                    end
                end
                state_next = NEXT;
            end
            NEXT: begin
                if (enable && (|chan_mask)) begin
                    chan_next  = pick_chan;
                    state_next = SELECT;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // Registered soc lines up exactly with the START state.
        soc_next = (state_next == START);
    end

    always_ff @(posedge clk_adc or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            cnt_reg          <= 16'd0;
            chan_reg         <= 3'd0;
            eoc_prev_reg     <= 1'b0;
            soc_reg          <= 1'b0;
            result_valid_reg <= 1'b0;
            result_data_reg  <= 12'd0;
            result_chan_reg  <= 3'd0;
            batt_level_reg   <= 2'd0;
            err_timeout_reg  <= 1'b0;
`ifdef ADC_SCAN_AVG_EN
            acc_reg          <= 14'd0;
            conv_reg         <= 2'd0;
`else
            sample_reg       <= 12'd0;
`endif
        end else begin
            state_reg        <= state_next;
            cnt_reg          <= cnt_next;
            chan_reg         <= chan_next;
            eoc_prev_reg     <= adc_eoc;
            soc_reg          <= soc_next;
            result_valid_reg <= result_valid_next;
            result_data_reg  <= result_data_next;
            result_chan_reg  <= result_chan_next;
            batt_level_reg   <= batt_level_next;
            err_timeout_reg  <= err_timeout_next;
`ifdef ADC_SCAN_AVG_EN
            acc_reg          <= acc_next;
            conv_reg         <= conv_next;
`else
            sample_reg       <= sample_next;
`endif
        end
    end

    assign adc_soc      = soc_reg;
    assign adc_s        = chan_reg;
    assign result_valid = result_valid_reg;
    assign result_data  = result_data_reg;
    assign result_chan  = result_chan_reg;
    assign batt_level   = batt_level_reg;
    assign err_timeout  = err_timeout_reg;

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_adc_scan_ctrl
//
// Directed bench for adc_scan_ctrl (SETTLE_CYC=4, TIMEOUT_CYC=16). A small ADC
// model raises adc_eoc for one cycle, 3 cycles after each observed adc_soc.
// With ADC_SCAN_AVG_EN defined, the averaging visit is exercised instead of
// the single-conversion sequence.
// -----------------------------------------------------------------------------
module tb_adc_scan_ctrl;

    logic        clk_adc = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [7:0]  chan_mask;
    logic        adc_eoc;
    logic [11:0] adc_dout;
    logic        adc_soc;
    logic [2:0]  adc_s;
    logic        result_valid;
    logic [11:0] result_data;
    logic [2:0]  result_chan;
    logic [1:0]  batt_level;
    logic        err_timeout;

    int n_cmp = 0;
    int n_err = 0;

    // ADC model controls
    logic        model_en;
    int          model_mode;   // 0 fixed, 1 0x100+chan, 2 sequence
    logic [11:0] model_fixed;
    logic [11:0] avg_seq [4];
    int          seq_idx;

    adc_scan_ctrl #(
        .SETTLE_CYC  (4),
        .TIMEOUT_CYC (16),
        .BATT_CH     (1),
        .BATT_HI     (2699),
        .BATT_LO     (2389)
    ) dut (
        .clk_adc      (clk_adc),
        .rst_n        (rst_n),
        .enable       (enable),
        .chan_mask    (chan_mask),
        .adc_eoc      (adc_eoc),
        .adc_dout     (adc_dout),
        .adc_soc      (adc_soc),
        .adc_s        (adc_s),
        .result_valid (result_valid),
        .result_data  (result_data),
        .result_chan  (result_chan),
        .batt_level   (batt_level),
        .err_timeout  (err_timeout)
    );

    always #5 clk_adc = ~clk_adc;

    // ADC macro model
    initial begin : adc_model
        int cd;
        cd = 0;
        adc_eoc  = 1'b0;
        adc_dout = 12'd0;
        forever begin
            @(posedge clk_adc);
            #1;
            adc_eoc = 1'b0;
            if (cd > 0) begin
                cd = cd - 1;
                if (cd == 0) begin
                    if (model_mode == 1) begin
                        adc_dout = 12'h100 + {9'd0, adc_s};
                    end else if (model_mode == 2) begin
                        adc_dout = avg_seq[seq_idx % 4];
                        seq_idx  = seq_idx + 1;
                    end else begin
                        adc_dout = model_fixed;
                    end
                    adc_eoc = 1'b1;
                end
            end
            if (adc_soc && model_en && rst_n) cd = 3;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_adc);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick(1);
            if (result_valid) ok = 1'b1;
        end
        check(tag, {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_soc(input string tag, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick(1);
            if (adc_soc) ok = 1'b1;
        end
        check(tag, {31'd0, ok}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_soc"},   {31'd0, adc_soc},      32'd0);
        check({tag, "_s"},     {29'd0, adc_s},        32'd0);
        check({tag, "_valid"}, {31'd0, result_valid}, 32'd0);
        check({tag, "_data"},  {20'd0, result_data},  32'd0);
        check({tag, "_chan"},  {29'd0, result_chan},  32'd0);
        check({tag, "_batt"},  {30'd0, batt_level},   32'd0);
        check({tag, "_err"},   {31'd0, err_timeout},  32'd0);
    endtask

    initial begin
        int bv [4];
        int bl [4];
        int exp_ch [4];
        int cnt;

        bv = '{2699, 2390, 2389, 0};
        bl = '{2, 2, 3, 3};
        exp_ch = '{0, 2, 7, 0};
        avg_seq[0] = 12'd100;
        avg_seq[1] = 12'd101;
        avg_seq[2] = 12'd102;
        avg_seq[3] = 12'd104;
        seq_idx     = 0;
        model_en    = 1'b1;
        model_mode  = 0;
        model_fixed = 12'd0;
        rst_n       = 1'b0;
        enable      = 1'b0;
        chan_mask   = 8'h00;

        tick(3);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick(2);

`ifndef ADC_SCAN_AVG_EN
        // Single channel 1, value 2700: soc exactly SETTLE+2 after leaving IDLE
        model_fixed = 12'd2700;
        chan_mask   = 8'h02;
        enable      = 1'b1;
        tick(6);
        check("soc_early", {31'd0, adc_soc}, 32'd0);
        tick(1);
        check("soc_time", {31'd0, adc_soc}, 32'd1);
        check("sel_ch1", {29'd0, adc_s}, 32'd1);
        tick(1);
        check("soc_one_cycle", {31'd0, adc_soc}, 32'd0);
        tick(3);
        check("valid_early", {31'd0, result_valid}, 32'd0);
        tick(1);
        check("valid_time", {31'd0, result_valid}, 32'd1);
        check("data_2700", {20'd0, result_data}, 32'd2700);
        check("chan_1", {29'd0, result_chan}, 32'd1);
        check("batt_2700", {30'd0, batt_level}, 32'd1);
        tick(1);
        check("valid_strobe", {31'd0, result_valid}, 32'd0);
        check("data_held", {20'd0, result_data}, 32'd2700);

        // Battery thresholds on the repeating single-channel scan
        for (int k = 0; k < 4; k++) begin
            model_fixed = 12'(bv[k]);
            wait_valid("batt_wait", 40);
            check("batt_data", {20'd0, result_data}, 32'(bv[k]));
            check("batt_level", {30'd0, batt_level}, 32'(bl[k]));
        end

        // Drop enable during WAIT: conversion completes, then idle
        model_fixed = 12'd1234;
        wait_soc("drop_soc_wait", 40);
        tick(1);
        enable = 1'b0;
        wait_valid("drop_valid_wait", 40);
        check("drop_data", {20'd0, result_data}, 32'd1234);
        check("drop_batt", {30'd0, batt_level}, 32'd3);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (adc_soc || result_valid) cnt++;
        end
        check("drop_idle", 32'(cnt), 32'd0);

        // Mask 0x85 round-robin: 0, 2, 7, wrap to 0
        model_mode = 1;
        chan_mask  = 8'h85;
        enable     = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_valid("rr_wait", 50);
            check("rr_chan", {29'd0, result_chan}, 32'(exp_ch[k]));
            check("rr_data", {20'd0, result_data}, 32'h100 + 32'(exp_ch[k]));
        end
        enable = 1'b0;
        tick(40);

        // Timeout: model silent, mask 0x09 (channels 0 and 3)
        model_en  = 1'b0;
        model_mode = 0;
        chan_mask = 8'h09;
        enable    = 1'b1;
        wait_soc("to_soc_wait", 40);
        check("to_sel_ch0", {29'd0, adc_s}, 32'd0);
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            if (result_valid) cnt++;
        end
        check("to_err_early", {31'd0, err_timeout}, 32'd0);
        tick(1);
        check("to_err_set", {31'd0, err_timeout}, 32'd1);
        tick(3);
        if (result_valid) cnt++;
        check("to_no_result", 32'(cnt), 32'd0);
        check("to_next_ch3", {29'd0, adc_s}, 32'd3);

        // Asynchronous reset in SETTLE
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        tick(2);
        rst_n  = 1'b1;
        enable = 1'b0;
        tick(2);
`else
        // Averaging visit on channel 0: 100,101,102,104 -> 407 >> 2 = 101
        model_mode = 2;
        seq_idx    = 0;
        chan_mask  = 8'h01;
        enable     = 1'b1;
        cnt = 0;
        begin
            bit ok;
            ok = 1'b0;
            for (int i = 0; i < 120 && !ok; i++) begin
                tick(1);
                if (adc_soc) cnt++;
                if (result_valid) ok = 1'b1;
            end
            check("avg_valid_wait", {31'd0, ok}, 32'd1);
        end
        enable = 1'b0;
        check("avg_data", {20'd0, result_data}, 32'd101);
        check("avg_chan", {29'd0, result_chan}, 32'd0);
        check("avg_soc_count", 32'(cnt), 32'd4);
        tick(1);
        check("avg_strobe", {31'd0, result_valid}, 32'd0);
        tick(30);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
